// File: rtl/eth_llc_rx_fifo.sv
// Store-and-forward receive FIFO for one LLC decoder channel: whole frames only, overruns drop the frame.
// Optional statistics counters are enabled by defining ETH_LLC_RX_FIFO_STAT_EN.
module eth_llc_rx_fifo #(
  parameter int DEPTH_LOG2 = 11,
  parameter int STAT_W     = 16
) (
  input  logic              clki,
  input  logic              rsti,
  input  logic [7:0]        s_axis_tdata,
  input  logic              s_axis_tvalid,
  input  logic              s_axis_tlast,
  output logic [7:0]        m_axis_tdata,
  output logic              m_axis_tvalid,
  output logic              m_axis_tlast,
  input  logic              m_axis_tready,
  output logic [STAT_W-1:0] frame_cnt_o,
  output logic [STAT_W-1:0] drop_cnt_o
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;
  localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0] DEPTH_P = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic [1:0] {IDLE, WR, DROP} wr_state_e;

  wr_state_e     state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] wr_cmt_q, wr_cmt_d;
  logic [PW-1:0] rd_ptr_q;
  logic          full, avail, wr_en, frame_inc, drop_inc;
  logic          issue, load_out;

  logic [8:0]    mem [DEPTH];
  logic          vld_p0_q, vld_p0_d;
  logic [8:0]    dat_p0_q;
  logic          vld_p1_q, vld_p1_d;
  logic [8:0]    dat_p1_q;

  assign full  = ((wr_ptr_q - rd_ptr_q) == DEPTH_P);
  assign avail = (rd_ptr_q != wr_cmt_q);

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    wr_cmt_d  = wr_cmt_q;
    wr_en     = 1'b0;
    frame_inc = 1'b0;
    drop_inc  = 1'b0;
    case (state_q)
      IDLE, WR: begin
        if (s_axis_tvalid) begin
          if (!full) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (s_axis_tlast) begin
              wr_cmt_d  = wr_ptr_q + PTR_ONE;
              frame_inc = 1'b1;
              state_d   = IDLE;
            end else begin
              state_d = WR;
            end
          end else begin
            // Overrun: discard the partial frame by rewinding to the last commit point
            wr_ptr_d = wr_cmt_q;
            drop_inc = 1'b1;
            state_d  = s_axis_tlast ? IDLE : DROP;
          end
        end
      end
      DROP: begin
        if (s_axis_tvalid && s_axis_tlast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Read pipeline: p0 holds the RAM read word, p1 is the output register
  assign load_out = vld_p0_q && (!vld_p1_q || m_axis_tready);
  assign issue    = avail && (!vld_p0_q || load_out);

  always_comb begin
    vld_p0_d = vld_p0_q;
    if (issue)         vld_p0_d = 1'b1;
    else if (load_out) vld_p0_d = 1'b0;
    vld_p1_d = vld_p1_q;
    if (load_out)           vld_p1_d = 1'b1;
    else if (m_axis_tready) vld_p1_d = 1'b0;
  end

  always_ff @(posedge clki) begin
    if (wr_en) mem[wr_ptr_q[DEPTH_LOG2-1:0]] <= {s_axis_tlast, s_axis_tdata};
    if (issue) dat_p0_q <= mem[rd_ptr_q[DEPTH_LOG2-1:0]];
  end

  always_ff @(posedge clki or posedge rsti) begin
    if (rsti) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      wr_cmt_q <= '0;
      rd_ptr_q <= '0;
      vld_p0_q <= 1'b0;
      vld_p1_q <= 1'b0;
      dat_p1_q <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      wr_cmt_q <= wr_cmt_d;
      if (issue) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      vld_p0_q <= vld_p0_d;
      vld_p1_q <= vld_p1_d;
      if (load_out) dat_p1_q <= dat_p0_q;
    end
  end

  assign m_axis_tvalid = vld_p1_q;
  assign m_axis_tlast  = dat_p1_q[8];
  assign m_axis_tdata  = dat_p1_q[7:0];

`ifdef ETH_LLC_RX_FIFO_STAT_EN
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] c);
    return (&c) ? c : c + {{(STAT_W-1){1'b0}}, 1'b1};
  endfunction

  logic [STAT_W-1:0] frame_cnt_q, drop_cnt_q;

  always_ff @(posedge clki or posedge rsti) begin
    if (rsti) begin
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      if (frame_inc) frame_cnt_q <= sat_inc(frame_cnt_q);
      if (drop_inc)  drop_cnt_q  <= sat_inc(drop_cnt_q);
    end
  end

  assign frame_cnt_o = frame_cnt_q;
  assign drop_cnt_o  = drop_cnt_q;
`else
  logic unused_stat;
  assign unused_stat = frame_inc ^ drop_inc;
  assign frame_cnt_o = '0;
  assign drop_cnt_o  = '0;
`endif

endmodule
